adder_lane_arbiter: RTL and testbench

- Shares one 32-bit ripple-carry adder (core_adder instance, external to this block) between the two issue lanes of the dual-issue core.
- Arbitrates round-robin with valid/ready on both sides, drives the adder operands, and captures each sum into a per-lane response register.
- Sits between the issue stage and the lane writeback paths; used for address and add-type ops when only one physical adder is instantiated.

---
 rtl/adder_lane_arbiter.sv | 99 +++++++++
 tb/tb_adder_lane_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_lane_arbiter.sv
// Round-robin arbiter that shares one external adder between two issue lanes,
// capturing each sum into a per-lane response register with valid/ready handshake.
module adder_lane_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [2*XLEN-1:0]    req_a_i,
    input  logic [2*XLEN-1:0]    req_b_i,
    input  logic [2*TAG_W-1:0]   req_tag_i,
    output logic [XLEN-1:0]      add_a_o,
    output logic [XLEN-1:0]      add_b_o,
    input  logic [XLEN-1:0]      add_sum_i,
    output logic [1:0]           rsp_valid_o,
    input  logic [1:0]           rsp_ready_i,
    output logic [2*XLEN-1:0]    rsp_data_o,
    output logic [2*TAG_W-1:0]   rsp_tag_o,
    output logic [CNT_W-1:0]     contention_cnt_o
);

    logic [1:0]         rsp_valid_q;
    logic [2*XLEN-1:0]  rsp_data_q;
    logic [2*TAG_W-1:0] rsp_tag_q;
    logic               prio_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [1:0] slot_free;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       contend;

    // A slot draining this cycle may be refilled in the same cycle.
    assign slot_free = ~rsp_valid_q | rsp_ready_i;
    assign eligible  = req_valid_i & slot_free;
    assign contend   = rst_ni & (eligible == 2'b11);

    always_comb begin
        grant = 2'b00;
        if (rst_ni) begin
            unique case (eligible)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_comb begin
        add_a_o = '0;
        add_b_o = '0;
        if (grant[0]) begin
            add_a_o = req_a_i[0 +: XLEN];
            add_b_o = req_b_i[0 +: XLEN];
        end else if (grant[1]) begin
            add_a_o = req_a_i[XLEN +: XLEN];
            add_b_o = req_b_i[XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (grant[k]) begin
                    rsp_valid_q[k]                 <= 1'b1;
                    rsp_data_q[k*XLEN +: XLEN]     <= add_sum_i;
                    rsp_tag_q[k*TAG_W +: TAG_W]    <= req_tag_i[k*TAG_W +: TAG_W];
                end else if (rsp_ready_i[k]) begin
                    rsp_valid_q[k] <= 1'b0;
                end
            end
            if (grant[0]) begin
                prio_q <= 1'b1;
            end else if (grant[1]) begin
                prio_q <= 1'b0;
            end
            if (contend && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign req_ready_o      = grant;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_tag_o        = rsp_tag_q;
    assign contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_adder_lane_arbiter.sv
// Directed bench for adder_lane_arbiter; models the external adder and checks
// grants, captured sums, backpressure, reset and counter saturation (CNT_W=4).
module tb_adder_lane_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*XLEN-1:0]   req_a;
    logic [2*XLEN-1:0]   req_b;
    logic [2*TAG_W-1:0]  req_tag;
    logic [XLEN-1:0]     add_a;
    logic [XLEN-1:0]     add_b;
    logic [XLEN-1:0]     add_sum;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [2*XLEN-1:0]   rsp_data;
    logic [2*TAG_W-1:0]  rsp_tag;
    logic [CNT_W-1:0]    cnt;

    int checks = 0;
    int passes = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    // Stand-in for the external core_adder: combinational, modulo 2^XLEN.
    assign add_sum = add_a + add_b;

    adder_lane_arbiter #(
        .XLEN (XLEN),
        .TAG_W(TAG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .req_tag_i       (req_tag),
        .add_a_o         (add_a),
        .add_b_o         (add_b),
        .add_sum_i       (add_sum),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data),
        .rsp_tag_o       (rsp_tag),
        .contention_cnt_o(cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [3:0] t0, input logic [3:0] t1);
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_tag   = {t1, t0};
        #1;
    endtask

    initial begin
        rst_ni    = 1'b0;
        rsp_ready = 2'b11;
        drive(2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 4'd1, 4'd2);
        check("rst_no_grant", 64'(req_ready), 64'(2'b00));
        tick();
        tick();
        check("rst_valid", 64'(rsp_valid), 64'(2'b00));
        check("rst_data", 64'(rsp_data), 64'd0);
        check("rst_tag", 64'(rsp_tag), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);

        // Single request on lane 0
        rst_ni = 1'b1;
        drive(2'b01, 32'h5, 32'h7, 32'h0, 32'h0, 4'd3, 4'd0);
        check("single_grant", 64'(req_ready), 64'(2'b01));
        check("single_opa", 64'(add_a), 64'h5);
        check("single_opb", 64'(add_b), 64'h7);
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0);
        check("idle_grant", 64'(req_ready), 64'(2'b00));
        check("idle_opa", 64'(add_a), 64'h0);
        check("single_valid", 64'(rsp_valid), 64'(2'b01));
        check("single_data", 64'(rsp_data[0 +: XLEN]), 64'h0000000C);
        check("single_tag", 64'(rsp_tag[0 +: TAG_W]), 64'd3);

        // Wrap-around on lane 1; lane 0 pops in the same cycle
        drive(2'b10, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 4'd0, 4'd5);
        check("wrap_grant", 64'(req_ready), 64'(2'b10));
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0);
        check("wrap_valid", 64'(rsp_valid), 64'(2'b10));
        check("wrap_data", 64'(rsp_data[XLEN +: XLEN]), 64'h0);
        check("wrap_tag", 64'(rsp_tag[TAG_W +: TAG_W]), 64'd5);
        check("wrap_lane0_held", 64'(rsp_data[0 +: XLEN]), 64'h0000000C);
        check("wrap_cnt", 64'(cnt), 64'd0);

        // Contention: prio back at lane 0, expect strict alternation
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'(10 + i), 32'h1, 32'(100 + i), 32'h2, 4'(i), 4'(8 + i));
            check("cont_grant", 64'(req_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            tick();
            if (i % 2 == 0) begin
                check("cont_data0", 64'(rsp_data[0 +: XLEN]), 64'(11 + i));
                check("cont_tag0", 64'(rsp_tag[0 +: TAG_W]), 64'(i));
            end else begin
                check("cont_data1", 64'(rsp_data[XLEN +: XLEN]), 64'(102 + i));
                check("cont_tag1", 64'(rsp_tag[TAG_W +: TAG_W]), 64'(8 + i));
            end
        end
        check("cont_cnt", 64'(cnt), 64'd4);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0);
        tick();
        check("cont_drained", 64'(rsp_valid), 64'(2'b00));

        // Backpressure: lane 0 result pending and not consumed
        rsp_ready = 2'b10;
        drive(2'b01, 32'h1234, 32'h1, 32'h0, 32'h0, 4'd6, 4'd0);
        tick();
        check("bp_fill", 64'(rsp_data[0 +: XLEN]), 64'h1235);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'h5555, 32'h1, 32'(200 + i), 32'h1, 4'd7, 4'd9);
            check("bp_grant", 64'(req_ready), 64'(2'b10));
            tick();
            check("bp_valid0", 64'(rsp_valid[0]), 64'd1);
            check("bp_data0", 64'(rsp_data[0 +: XLEN]), 64'h1235);
            check("bp_tag0", 64'(rsp_tag[0 +: TAG_W]), 64'd6);
            check("bp_data1", 64'(rsp_data[XLEN +: XLEN]), 64'(201 + i));
            check("bp_cnt", 64'(cnt), 64'd4);
        end
        rsp_ready = 2'b11;
        drive(2'b11, 32'h5555, 32'h1, 32'h300, 32'h1, 4'd7, 4'd9);
        check("bp_popfill", 64'(req_ready), 64'(2'b01));
        tick();
        check("bp_newdata0", 64'(rsp_data[0 +: XLEN]), 64'h5556);
        check("bp_newtag0", 64'(rsp_tag[0 +: TAG_W]), 64'd7);
        check("bp_cnt5", 64'(cnt), 64'd5);

        // Reset mid-operation
        rsp_ready = 2'b00;
        drive(2'b10, 32'h0, 32'h0, 32'h40, 32'h2, 4'd0, 4'd4);
        check("mid_grant1", 64'(req_ready), 64'(2'b10));
        tick();
        rst_ni = 1'b0;
        drive(2'b11, 32'h1, 32'h1, 32'h50, 32'h2, 4'd1, 4'd4);
        check("mid_rst_nogrant", 64'(req_ready), 64'(2'b00));
        tick();
        rst_ni = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0);
        check("mid_valid", 64'(rsp_valid), 64'(2'b00));
        check("mid_data", 64'(rsp_data), 64'd0);
        check("mid_cnt", 64'(cnt), 64'd0);
        rsp_ready = 2'b11;
        drive(2'b11, 32'h20, 32'h3, 32'h60, 32'h3, 4'd2, 4'd3);
        check("mid_prio0", 64'(req_ready), 64'(2'b01));
        tick();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0);
        check("mid_nostale", 64'(rsp_valid), 64'(2'b01));
        check("mid_data0", 64'(rsp_data[0 +: XLEN]), 64'h23);

        // Saturation of the 4-bit contention counter
        exp_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, 32'(i), 32'h0, 32'(i), 32'h1, 4'd0, 4'd0);
            tick();
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            check("sat_cnt", 64'(cnt), 64'(exp_cnt));
        end
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0);
        tick();
        check("sat_hold", 64'(cnt), 64'd15);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
